// File: rtl/product_accumulator_if.sv
// Valid-qualified product stream into the accumulator and the per-frame result back out.
// The producer holds the master modport; the accumulator holds the slave modport.
interface product_accumulator_if #(
   parameter int DATAWIDTH = 4,
   parameter int ACC_LEN   = 8,
   parameter int ACCWIDTH  = 2*DATAWIDTH + $clog2(ACC_LEN)
);
   localparam int PRODW = 2*DATAWIDTH;
   localparam int CNTW  = $clog2(ACC_LEN+1);

   logic             i_valid;
   logic [PRODW-1:0] i_product;
   logic             i_last;
   logic             i_clear;

   logic                o_valid;
   logic [ACCWIDTH-1:0] o_sum;
   logic [CNTW-1:0]     o_count;
   logic                o_overflow;

   modport master (
      output i_valid, i_product, i_last, i_clear,
      input  o_valid, o_sum, o_count, o_overflow
   );

   modport slave (
      input  i_valid, i_product, i_last, i_clear,
      output o_valid, o_sum, o_count, o_overflow
   );
endinterface

// File: rtl/product_accumulator.sv
// Frame accumulator for the multiplier's product stream: sums up to ACC_LEN products per
// frame (or fewer on i_last) and presents one registered sum per frame with a 1-cycle pulse.
module product_accumulator #(
   parameter int DATAWIDTH   = 4,
   parameter int ACC_LEN     = 8,
   parameter int ACCWIDTH    = 2*DATAWIDTH + $clog2(ACC_LEN),
   parameter int INSTANCE_ID = 0
) (
   input logic                  clk,
   input logic                  rst,
   product_accumulator_if.slave bus
);
   localparam int PRODW = 2*DATAWIDTH;
   localparam int CNTW  = $clog2(ACC_LEN+1);
   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(ACC_LEN);

   generate
      if (ACC_LEN < 1 || ACCWIDTH < PRODW || INSTANCE_ID < 0) begin : g_bad_params
         $error("product_accumulator: illegal parameter combination");
      end
   endgenerate

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ACCWIDTH-1:0] acc_q, acc_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic                ovf_q, ovf_d;

   logic                valid_q, valid_d;
   logic [ACCWIDTH-1:0] sum_q, sum_d;
   logic [CNTW-1:0]     count_q, count_d;
   logic                oflow_q, oflow_d;

   logic [ACCWIDTH-1:0] acc_base;
   logic [ACCWIDTH:0]   sum_ext;
   logic [CNTW-1:0]     cnt_inc;
   logic                ovf_inc;
   logic                closing;

   // In IDLE the accumulator is known to be empty, so the adder starts from zero there.
   always_comb begin
      acc_base = (state_q == ACCUM) ? acc_q : '0;
      sum_ext  = (ACCWIDTH+1)'(acc_base) + (ACCWIDTH+1)'(bus.i_product);
      cnt_inc  = cnt_q + CNTW'(1);
      ovf_inc  = ovf_q | sum_ext[ACCWIDTH];
      closing  = bus.i_last || (cnt_inc == CNT_MAX);
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      sum_d   = sum_q;
      count_d = count_q;
      oflow_d = oflow_q;

      if (bus.i_clear) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else if (bus.i_valid) begin
         if (closing) begin
            valid_d = 1'b1;
            sum_d   = sum_ext[ACCWIDTH-1:0];
            count_d = cnt_inc;
            oflow_d = ovf_inc;
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
         end else begin
            state_d = ACCUM;
            acc_d   = sum_ext[ACCWIDTH-1:0];
            cnt_d   = cnt_inc;
            ovf_d   = ovf_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         sum_q   <= '0;
         count_q <= '0;
         oflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         oflow_q <= oflow_d;
      end
   end

   assign bus.o_valid    = valid_q;
   assign bus.o_sum      = sum_q;
   assign bus.o_count    = count_q;
   assign bus.o_overflow = oflow_q;
endmodule
